// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage front end. Takes one load/store per handshake from EX and drives a
// word-organised data memory (combinational read, synchronous word write).
// Byte and halfword stores are done as a two-cycle read-modify-write; loads are
// lane-selected, sign/zero extended and registered towards MEM/WB.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               request from EX (valid/ready handshake)
//   resp_*              registered load result / error pulse
//   DataMemWE/Addr/In   word write port to data memory
//   DataMemOut          combinational read word from data memory
//
// States:
//   state  | meaning
//   IDLE   | ready for a request; word stores write directly here
//   RMW_WR | writing the merged word of a byte/halfword store
// -----------------------------------------------------------------------------
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        DataMemWE,
    output logic [31:0] DataMemAddr,
    output logic [31:0] DataMemIn,
    input  logic [31:0] DataMemOut
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [31:0] rmw_data_q, rmw_data_d;

    logic        accept;
    logic        req_err;
    logic [31:0] word_addr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign word_addr = {req_addr[31:2], 2'b00};

    // Alignment / reserved-size decode
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Load lane select and extension
    always_comb begin
        ld_byte = DataMemOut[7:0];
        case (req_addr[1:0])
            2'd0:    ld_byte = DataMemOut[7:0];
            2'd1:    ld_byte = DataMemOut[15:8];
            2'd2:    ld_byte = DataMemOut[23:16];
            default: ld_byte = DataMemOut[31:24];
        endcase
        ld_half = req_addr[1] ? DataMemOut[31:16] : DataMemOut[15:0];
        case (req_size)
            SZ_BYTE: load_ext = {{24{req_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_ext = {{16{req_signed & ld_half[15]}}, ld_half};
            default: load_ext = DataMemOut;
        endcase
    end

    // Store merge: current memory word with one lane replaced
    always_comb begin
        merged = DataMemOut;
        if (req_size == SZ_BYTE) begin
            case (req_addr[1:0])
                2'd0:    merged[7:0]   = req_wdata[7:0];
                2'd1:    merged[15:8]  = req_wdata[7:0];
                2'd2:    merged[23:16] = req_wdata[7:0];
                default: merged[31:24] = req_wdata[7:0];
            endcase
        end else if (req_addr[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0]  = req_wdata[15:0];
        end
    end

    // Next state, response and memory port
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_data_d   = rmw_data_q;
        mem_we       = 1'b0;
        mem_addr     = word_addr;
        mem_wdata    = req_wdata;

        if (state_q == RMW_WR) begin
            mem_we    = 1'b1;
            mem_addr  = rmw_addr_q;
            mem_wdata = rmw_data_q;
            state_d   = IDLE;
        end else if (accept) begin
            if (req_err) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = 32'h0;
                resp_rd_d    = req_rd;
            end else if (!req_we) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = load_ext;
                resp_rd_d    = req_rd;
            end else if (req_size == SZ_WORD) begin
                mem_we = 1'b1;
            end else begin
                rmw_addr_d = word_addr;
                rmw_data_d = merged;
                state_d    = RMW_WR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_rd_q    <= 5'h0;
            resp_err_q   <= 1'b0;
            rmw_addr_q   <= 32'h0;
            rmw_data_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_data_q   <= rmw_data_d;
        end
    end

    // Gated with rst_n so a reset landing in RMW_WR can never commit the write
    assign DataMemWE   = mem_we & rst_n;
    assign DataMemAddr = mem_addr;
    assign DataMemIn   = mem_wdata;

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_rd     = resp_rd_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        DataMemWE;
    logic [31:0] DataMemAddr;
    logic [31:0] DataMemIn;
    logic [31:0] DataMemOut;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_err(resp_err),
        .DataMemWE(DataMemWE), .DataMemAddr(DataMemAddr), .DataMemIn(DataMemIn),
        .DataMemOut(DataMemOut)
    );

    always #5 clk = ~clk;

    // Environment memory: 64 words covering byte addresses 0x00..0xFF
    logic [31:0] tb_mem   [64];
    logic [31:0] init_img [64];
    logic        load_mem = 1'b1;
    assign DataMemOut = tb_mem[DataMemAddr[7:2]];

    always @(posedge clk) begin
        if (load_mem) tb_mem <= init_img;
        else if (DataMemWE) tb_mem[DataMemAddr[7:2]] <= DataMemIn;
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int writes = 0;
    int exp_writes = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          at_cyc;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rst_n && DataMemWE) begin
            writes++;
            checks++;
            if (DataMemAddr[1:0] != 2'b00) begin
                failures++;
                $display("FAIL we_addr_align got=%h want low bits 00", DataMemAddr);
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_spurious cyc=%0d rdata=%h rd=%0d err=%0b", cyc, resp_rdata, resp_rd, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_rdata !== e.rdata || resp_rd !== e.rd || resp_err !== e.err || cyc != e.at_cyc) begin
                    failures++;
                    $display("FAIL resp got rdata=%h rd=%0d err=%0b cyc=%0d want rdata=%h rd=%0d err=%0b cyc=%0d",
                             resp_rdata, resp_rd, resp_err, cyc, e.rdata, e.rd, e.err, e.at_cyc);
                end
            end
        end
    end

    function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int sh;
        w  = ref_mem[a[7:2]];
        sh = 8 * int'(a % 4);
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(a % 4);
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a negedge; leaves req_valid high so the caller can go back-to-back
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int tries;
        logic err;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_rd = rd;
        tries = 0;
        while (!req_ready) begin
            @(negedge clk);
            tries++;
            if (tries > 10) begin
                checks++; failures++;
                $display("FAIL accept_timeout addr=%h waited=%0d cycles", a, tries);
                req_valid = 1'b0;
                return;
            end
        end
        err = is_err(sz, a);
        if (err) begin
            exp_q.push_back('{32'h0, rd, 1'b1, cyc + 1});
        end else if (!we) begin
            exp_q.push_back('{ref_load(sz, sg, a), rd, 1'b0, cyc + 1});
        end else begin
            ref_store(sz, a, wd);
            exp_writes++;
        end
        @(negedge clk);
        if (we && !err) check(sz == 2'd2 ? "ready_after_word_store" : "ready_low_in_rmw",
                              {31'h0, req_ready}, {31'h0, sz == 2'd2});
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int wr_before;
    logic [31:0] saved;

    initial begin
        for (int i = 0; i < 64; i++) begin
            init_img[i] = $urandom;
            ref_mem[i]  = init_img[i];
        end
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_rd",    {27'h0, resp_rd}, 32'h0);
        check("rst_resp_err",   {31'h0, resp_err}, 32'h0);
        check("rst_we",         {31'h0, DataMemWE}, 32'h0);
        load_mem = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Word store then load
        issue(1, 2'd2, 0, 32'h20, 32'hDEADBEEF, 0);
        issue(0, 2'd2, 0, 32'h20, 32'h0, 5'd5);
        idle(2);

        // Reset in the middle of an RMW
        saved = ref_mem[4];
        issue(1, 2'd0, 0, 32'h10, 32'h5A, 0);
        rst_n = 1'b0;
        ref_mem[4] = saved;
        exp_writes--;
        req_valid = 1'b0;
        #1;
        check("midrmw_we",         {31'h0, DataMemWE}, 32'h0);
        check("midrmw_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("midrmw_resp_rdata", resp_rdata, 32'h0);
        check("midrmw_resp_rd",    {27'h0, resp_rd}, 32'h0);
        check("midrmw_resp_err",   {31'h0, resp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_midrmw_rst", {31'h0, req_ready}, 32'h1);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 5'd1);

        // Byte RMW and extension
        issue(1, 2'd2, 0, 32'h30, 32'h11223344, 0);
        issue(1, 2'd0, 0, 32'h32, 32'hAA, 0);
        issue(0, 2'd2, 0, 32'h30, 32'h0, 5'd2);
        issue(0, 2'd0, 1, 32'h32, 32'h0, 5'd3);
        issue(0, 2'd0, 0, 32'h32, 32'h0, 5'd4);

        // Halfword
        issue(1, 2'd2, 0, 32'h40, 32'h0, 0);
        issue(1, 2'd1, 0, 32'h42, 32'h8001, 0);
        issue(0, 2'd1, 1, 32'h42, 32'h0, 5'd6);
        issue(0, 2'd1, 0, 32'h40, 32'h0, 5'd7);
        idle(1);

        // Misalignment and reserved size
        wr_before = writes;
        issue(1, 2'd2, 0, 32'h21, 32'h12345678, 5'd8);
        issue(0, 2'd1, 0, 32'h43, 32'h0, 5'd9);
        issue(1, 2'd3, 0, 32'h50, 32'hFFFFFFFF, 5'd10);
        idle(2);
        check("err_no_writes", writes, wr_before);

        // Back-to-back: byte store then word load held valid
        issue(1, 2'd0, 0, 32'h60, 32'h77, 0);
        issue(0, 2'd2, 0, 32'h60, 32'h0, 5'd11);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & ~32'h1;
                if (sz == 2'd2) a = a & ~32'h3;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        check("write_count", writes, exp_writes);
        for (int i = 0; i < 64; i++) check("final_mem", tb_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
